// File: rtl/periph_bus.sv
// Memory-mapped peripheral window: reloading timer with irq, LED and 7-seg registers, systick.
// Reads are combinational from addr; writes and timer/systick updates land on the rising clk edge.
module periph_bus #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              sel,
  output logic [31:0]       rdata,
  output logic              irq,
  output logic [LED_W-1:0]  leds,
  output logic [11:0]       digits
);

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LEDS    = 3'd3;
  localparam logic [2:0] OFF_DIGITS  = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  logic [31:0]      r_th;
  logic [31:0]      r_tl;
  logic [2:0]       r_tcon;
  logic [LED_W-1:0] r_leds;
  logic [11:0]      r_digits;
  logic [31:0]      r_systick;

  logic             w_sel;
  logic [2:0]       w_off;
  logic             w_wr;
  logic             w_ovf;

  // 32-byte aligned window: only the upper 27 address bits decode.
  assign w_sel = (addr[31:5] == BASE_ADDR[31:5]);
  assign w_off = addr[4:2];
  assign w_wr  = mem_write && w_sel;
  assign w_ovf = r_tcon[0] && (r_tl == 32'hFFFF_FFFF);

  always_comb begin
    rdata = 32'd0;
    if (w_sel && mem_read) begin
      case (w_off)
        OFF_TH:      rdata = r_th;
        OFF_TL:      rdata = r_tl;
        OFF_TCON:    rdata = {29'd0, r_tcon};
        OFF_LEDS:    rdata = {{(32-LED_W){1'b0}}, r_leds};
        OFF_DIGITS:  rdata = {20'd0, r_digits};
        OFF_SYSTICK: rdata = r_systick;
        default:     rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th      <= 32'd0;
      r_tl      <= 32'd0;
      r_tcon    <= 3'd0;
      r_leds    <= '0;
      r_digits  <= 12'd0;
      r_systick <= 32'd0;
    end else begin
      if (w_wr && (w_off == OFF_TH))
        r_th <= wdata;

      // A CPU write to TL beats both the increment and the reload.
      if (w_wr && (w_off == OFF_TL))
        r_tl <= wdata;
      else if (w_ovf)
        r_tl <= r_th;
      else if (r_tcon[0])
        r_tl <= r_tl + 32'd1;

      // Writing TCON in an overflow cycle drops that overflow's status.
      if (w_wr && (w_off == OFF_TCON))
        r_tcon <= wdata[2:0];
      else if (w_ovf && r_tcon[1])
        r_tcon[2] <= 1'b1;

      if (w_wr && (w_off == OFF_LEDS))
        r_leds <= wdata[LED_W-1:0];

      if (w_wr && (w_off == OFF_DIGITS))
        r_digits <= wdata[11:0];

      if (w_wr && (w_off == OFF_SYSTICK))
        r_systick <= wdata;
      else
        r_systick <= r_systick + 32'd1;
    end
  end

  assign sel    = w_sel;
  assign irq    = r_tcon[2];
  assign leds   = r_leds;
  assign digits = r_digits;

endmodule

// File: tb/tb_periph_bus.sv
// Directed bench for periph_bus: decode, timer reload/irq, write races, async reset.
module tb_periph_bus;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        sel;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digits;

  int n_chk  = 0;
  int n_fail = 0;

  periph_bus #(.BASE_ADDR(BASE), .LED_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .sel       (sel),
    .rdata     (rdata),
    .irq       (irq),
    .leds      (leds),
    .digits    (digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Store: drive strobes, let one rising edge capture them, end 1ns after the edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr     = a;
    mem_read = 1'b1;
    #1;
    d        = rdata;
    mem_read = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] v;

  initial begin
    reset     = 1'b0;
    addr      = BASE + 32'hC;
    wdata     = 32'hFF;
    mem_read  = 1'b0;
    mem_write = 1'b1;

    // 1: writes under reset are blocked; systick counts from release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_leds", {24'd0, leds}, 32'd0);
    chk("rst_digits", {20'd0, digits}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_sel", {31'd0, sel}, 32'd1);
    mem_write = 1'b0;
    rd(BASE + 32'h14, v); chk("rst_systick", v, 32'd0);
    reset = 1'b1;
    rd(BASE + 32'h14, v); chk("systick_0", v, 32'd0);
    tick(); rd(BASE + 32'h14, v); chk("systick_1", v, 32'd1);
    tick(); rd(BASE + 32'h14, v); chk("systick_2", v, 32'd2);

    // 2: decode
    wr(BASE + 32'hC, 32'h0000_00A5);
    chk("leds_a5", {24'd0, leds}, 32'hA5);
    rd(BASE + 32'hC, v); chk("rd_leds", v, 32'hA5);
    addr = BASE + 32'hC; #1;
    chk("rd_no_strobe", rdata, 32'd0);
    rd(BASE + 32'h20, v); chk("out_of_window", v, 32'd0);
    chk("sel_out", {31'd0, sel}, 32'd0);
    wr(BASE + 32'h18, 32'h1234_5678);
    rd(BASE + 32'h18, v); chk("reserved_rd", v, 32'd0);
    chk("leds_kept", {24'd0, leds}, 32'hA5);
    wr(BASE + 32'h10, 32'h0000_1ABC);
    chk("digits_trunc", {20'd0, digits}, 32'hABC);
    wr(BASE + 32'h14, 32'd100);
    rd(BASE + 32'h14, v); chk("systick_load", v, 32'd100);
    tick(); rd(BASE + 32'h14, v); chk("systick_inc", v, 32'd101);

    // 3: reload and sticky irq
    wr(BASE + 32'h0, 32'hFFFF_FFFE);
    wr(BASE + 32'h4, 32'hFFFF_FFFD);
    wr(BASE + 32'h8, 32'd3);
    rd(BASE + 32'h4, v); chk("tl_start", v, 32'hFFFF_FFFD);
    tick(); rd(BASE + 32'h4, v); chk("tl_fffe", v, 32'hFFFF_FFFE);
    chk("irq_pre", {31'd0, irq}, 32'd0);
    tick(); rd(BASE + 32'h4, v); chk("tl_ffff", v, 32'hFFFF_FFFF);
    chk("irq_pre2", {31'd0, irq}, 32'd0);
    tick(); rd(BASE + 32'h4, v); chk("tl_reload", v, 32'hFFFF_FFFE);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    tick(); rd(BASE + 32'h4, v); chk("tl_after", v, 32'hFFFF_FFFF);
    chk("irq_sticky", {31'd0, irq}, 32'd1);

    // 4: TCON write in the overflow cycle wins; status lost, TL reloads
    wr(BASE + 32'h8, 32'd3);
    chk("race_irq", {31'd0, irq}, 32'd0);
    rd(BASE + 32'h4, v); chk("race_tl", v, 32'hFFFF_FFFE);
    rd(BASE + 32'h8, v); chk("race_tcon", v, 32'd3);

    // 5: irq disabled through a wrap, then timer frozen
    wr(BASE + 32'h8, 32'd1);
    rd(BASE + 32'h4, v); chk("dis_tl_ffff", v, 32'hFFFF_FFFF);
    tick(); rd(BASE + 32'h4, v); chk("dis_tl_reload", v, 32'hFFFF_FFFE);
    chk("dis_irq", {31'd0, irq}, 32'd0);
    wr(BASE + 32'h8, 32'd0);
    repeat (10) tick();
    rd(BASE + 32'h4, v); chk("frozen_tl", v, 32'hFFFF_FFFF);

    // 6: async reset between edges
    wr(BASE + 32'h8, 32'd3);
    tick();
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_irq", {31'd0, irq}, 32'd0);
    rd(BASE + 32'h4, v); chk("arst_tl", v, 32'd0);
    rd(BASE + 32'h8, v); chk("arst_tcon", v, 32'd0);
    chk("arst_leds", {24'd0, leds}, 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    rd(BASE + 32'h4, v); chk("tl_idle_after_rst", v, 32'd0);
    rd(BASE + 32'h14, v); chk("systick_after_rst", v, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
